// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an 8-entry register file.
// Tracks outstanding writes and gates issue on RAW/WAW hazards.
module hazard_scoreboard #(
  parameter int BYPASS  = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic [2:0]         issue_rs,
  input  logic [2:0]         issue_rt,
  input  logic               issue_uses_rs,
  input  logic               issue_uses_rt,
  input  logic               issue_writes,
  input  logic [2:0]         issue_rd,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  logic [2:0]         wb_rd,
  input  logic               flush,
  output logic [7:0]         pending,
  output logic               busy,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [STALL_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_W-1:0] STALL_ONE =
    {{(STALL_W-1){1'b0}}, 1'b1};

  logic [7:0]         pend_q;
  logic [7:0]         pend_d;
  logic [7:0]         wb_dec;
  logic [7:0]         set_dec;
  logic [7:0]         byp_dec;
  logic [7:0]         eff_pend;
  logic               hz_rs;
  logic               hz_rt;
  logic               hz_rd;
  logic               fire;
  logic               stall_inc;
  logic [STALL_W-1:0] stall_q;

  always_comb begin
    wb_dec = '0;
    if (wb_valid) wb_dec[wb_rd] = 1'b1;
  end

  assign byp_dec  = (BYPASS != 0) ? wb_dec : 8'h00;
  assign eff_pend = pend_q & ~byp_dec;

  // r0 never holds a pending bit, so it can never hazard.
  assign hz_rs = issue_uses_rs & eff_pend[issue_rs];
  assign hz_rt = issue_uses_rt & eff_pend[issue_rt];
  assign hz_rd = issue_writes  & eff_pend[issue_rd];

  assign issue_ready = ~(hz_rs | hz_rt | hz_rd);
  assign fire        = issue_valid & issue_ready & ~flush;

  always_comb begin
    set_dec = '0;
    if (fire && issue_writes && issue_rd != 3'd0)
      set_dec[issue_rd] = 1'b1;
  end

  // Set wins over a same-cycle clear; flush wins over both.
  always_comb begin
    pend_d = '0;
    if (!flush)
      pend_d = (pend_q & ~wb_dec) | set_dec;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign stall_inc = issue_valid & ~issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (stall_inc && stall_q != STALL_MAX)
      stall_q <= stall_q + STALL_ONE;
  end

  assign pending     = pend_q;
  assign busy        = |pend_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one stimulus
// stream and are compared every cycle against a register-list model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_rs = '0;
  logic [2:0] issue_rt = '0;
  logic       issue_uses_rs = 1'b0;
  logic       issue_uses_rt = 1'b0;
  logic       issue_writes = 1'b0;
  logic [2:0] issue_rd = '0;
  logic       wb_valid = 1'b0;
  logic [2:0] wb_rd = '0;
  logic       flush = 1'b0;

  logic        rdy_a, rdy_b, rdy_c;
  logic [7:0]  pend_a, pend_b, pend_c;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] st_a, st_b;
  logic [3:0]  st_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.BYPASS(1), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_writes(issue_writes), .issue_rd(issue_rd),
    .issue_ready(rdy_a), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .pending(pend_a), .busy(busy_a),
    .stall_count(st_a));

  hazard_scoreboard #(.BYPASS(0), .STALL_W(16)) dut_nb (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_writes(issue_writes), .issue_rd(issue_rd),
    .issue_ready(rdy_b), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .pending(pend_b), .busy(busy_b),
    .stall_count(st_b));

  hazard_scoreboard #(.BYPASS(1), .STALL_W(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_writes(issue_writes), .issue_rd(issue_rd),
    .issue_ready(rdy_c), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .pending(pend_c), .busy(busy_c),
    .stall_count(st_c));

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: per config, a list of registers with an outstanding write.
  bit          m_out[3][8];
  int unsigned m_st[3];
  int          m_byp[3] = '{1, 0, 1};
  int unsigned m_lim[3] = '{65535, 65535, 15};

  function automatic bit m_blocked(int k, logic [2:0] r, bit used);
    bit retiring;
    if (!used || r == 3'd0) return 1'b0;
    retiring = (m_byp[k] != 0) && wb_valid && wb_rd == r;
    return m_out[k][r] && !retiring;
  endfunction

  function automatic bit m_ready(int k);
    return !(m_blocked(k, issue_rs, issue_uses_rs) ||
             m_blocked(k, issue_rt, issue_uses_rt) ||
             m_blocked(k, issue_rd, issue_writes));
  endfunction

  function automatic logic [7:0] m_pend(int k);
    logic [7:0] v = '0;
    for (int r = 0; r < 8; r++) v[r] = m_out[k][r];
    return v;
  endfunction

  always @(negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0;
      for (int r = 0; r < 8; r++) m_out[k][r] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        bit rdy;
        bit fired;
        rdy = m_ready(k);
        fired = issue_valid && rdy && !flush;
        if (issue_valid && !rdy && m_st[k] < m_lim[k]) m_st[k]++;
        if (flush) begin
          for (int r = 0; r < 8; r++) m_out[k][r] = 1'b0;
        end else begin
          if (wb_valid) m_out[k][wb_rd] = 1'b0;
          if (fired && issue_writes && issue_rd != 3'd0)
            m_out[k][issue_rd] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0]  p[3];
    logic        rd[3];
    logic        b[3];
    logic [31:0] s[3];
    p  = '{pend_a, pend_b, pend_c};
    rd = '{rdy_a, rdy_b, rdy_c};
    b  = '{busy_a, busy_b, busy_c};
    s  = '{32'(st_a), 32'(st_b), 32'(st_c)};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_pending%0d", k), 32'(p[k]), 32'(m_pend(k)));
      check($sformatf("model_ready%0d", k), 32'(rd[k]), 32'(m_ready(k)));
      check($sformatf("model_busy%0d", k), 32'(b[k]),
            32'(m_pend(k) != 8'h00));
      check($sformatf("model_stall%0d", k), s[k], m_st[k]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0;
    issue_writes = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic wr(input logic [2:0] rd);
    idle();
    issue_valid = 1; issue_writes = 1; issue_rd = rd;
  endtask

  initial begin
    // Reset holds ready high even with a hazardous-looking issue.
    issue_valid = 1; issue_uses_rs = 1; issue_rs = 3;
    issue_writes = 1; issue_rd = 3;
    #3;
    check("rst_pending", 32'(pend_a), 32'h00);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_ready", 32'(rdy_a), 32'h1);
    check("rst_stall", 32'(st_a), 32'h0);
    idle();
    #9 rst_n = 1;
    cyc();

    wr(3'd3);
    cyc();
    check("set_r3_pending", 32'(pend_a), 32'h08);
    check("set_r3_busy", 32'(busy_a), 32'h1);

    idle();
    issue_valid = 1; issue_uses_rs = 1; issue_rs = 3;
    #1 check("raw_ready", 32'(rdy_a), 32'h0);
    cyc(); cyc(); cyc();
    check("raw_stall3", 32'(st_a), 32'd3);

    wb_valid = 1; wb_rd = 3;
    #1;
    check("bypass_ready_b1", 32'(rdy_a), 32'h1);
    check("bypass_ready_b0", 32'(rdy_b), 32'h0);
    cyc();
    check("wb_clear_b1", 32'(pend_a), 32'h00);
    check("wb_clear_b0", 32'(pend_b), 32'h00);
    check("nb_stall4", 32'(st_b), 32'd4);
    idle();
    cyc();

    wr(3'd5);
    cyc();
    #1 check("waw_ready", 32'(rdy_a), 32'h0);
    wb_valid = 1; wb_rd = 5;
    cyc();
    check("waw_set_wins", 32'(pend_a), 32'h20);
    check("waw_nb_cleared", 32'(pend_b), 32'h00);
    idle();
    wb_valid = 1; wb_rd = 5;
    cyc();

    idle();
    issue_valid = 1; issue_writes = 1; issue_rd = 0;
    issue_uses_rs = 1; issue_rs = 0;
    #1 check("r0_ready", 32'(rdy_a), 32'h1);
    cyc();
    check("r0_no_pending", 32'(pend_a), 32'h00);

    for (int r = 1; r < 8; r++) begin
      wr(3'(r));
      cyc();
    end
    check("all_pending", 32'(pend_a), 32'hFE);
    wr(3'd2);
    flush = 1;
    cyc();
    check("flush_clears", 32'(pend_a), 32'h00);
    wr(3'd4);
    flush = 1;
    cyc();
    check("flush_blocks_set", 32'(pend_a), 32'h00);

    wr(3'd6);
    cyc();
    idle();
    issue_valid = 1; issue_uses_rt = 1; issue_rt = 6;
    repeat (20) cyc();
    check("stall_saturate", 32'(st_c), 32'hF);

    #1 rst_n = 0;
    #1;
    check("async_pending", 32'(pend_a), 32'h00);
    check("async_stall", 32'(st_c), 32'h0);
    check("async_ready", 32'(rdy_a), 32'h1);
    rst_n = 1;
    cyc();

    for (int i = 0; i < 60; i++) begin
      issue_valid   = 1'($urandom);
      issue_rs      = 3'($urandom);
      issue_rt      = 3'($urandom);
      issue_rd      = 3'($urandom);
      issue_uses_rs = 1'($urandom);
      issue_uses_rt = 1'($urandom);
      issue_writes  = 1'($urandom);
      wb_valid      = 1'($urandom);
      wb_rd         = 3'($urandom);
      flush         = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
